lsu_dmem_np: RTL and testbench

- Parametrised N-port load/store execution stage with private data memory.
- Successor to the fixed dual-port 16-bit data-cache stage.
- Sits after issue and before register-file writeback. Each port carries one load/store/immediate op per cycle and returns a writeback triple three cycles later.
- Adds over the previous generation:
  - reset with a memory-zeroing init FSM,
  - deterministic multi-port store-conflict priority,
  - atomic swap,
  - out-of-range address fault reporting.

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_dmem_array.sv | 29 ++
 rtl/lsu_dmem_np.sv | 128 ++++++++++++
 tb/tb_lsu_dmem_np.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared widths, opcodes and FSM states for the N-port load/store stage
package lsu_pkg;
    localparam int LSU_NUM_PORTS  = 2;
    localparam int LSU_DATA_W     = 16;
    localparam int LSU_DEPTH      = 2048;
    localparam int LSU_ADDR_W     = 11;
    localparam int LSU_REG_ADDR_W = 5;
    localparam int LSU_OPCODE_W   = 7;

    localparam int OP_NOP = 0;
    localparam int OP_LDI = 10;
    localparam int OP_LD  = 11;
    localparam int OP_ST  = 12;
    localparam int OP_SWP = 13;

    typedef enum logic {INIT, RUN} lsuState_e;
endpackage

// File: rtl/lsu_dmem_array.sv
// lsu_dmem_array: data memory with N async read ports, N index-priority write ports and an overriding init port
module lsu_dmem_array import lsu_pkg::*; #(
    parameter int NUM_PORTS = LSU_NUM_PORTS,
    parameter int DATA_W    = LSU_DATA_W,
    parameter int DEPTH     = LSU_DEPTH,
    parameter int ADDR_W    = LSU_ADDR_W
) (
    input  logic                                clock_i,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    rdAddr,
    output logic [NUM_PORTS-1:0][DATA_W-1:0]    rdData,
    input  logic [NUM_PORTS-1:0]                wrEnable,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]    wrAddr,
    input  logic [NUM_PORTS-1:0][DATA_W-1:0]    wrData,
    input  logic                                initEnable,
    input  logic [ADDR_W-1:0]                   initAddr
);
    logic [DATA_W-1:0] mem [DEPTH];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : gRead
        assign rdData[g] = mem[rdAddr[g]];
    end

    // Later assignments win, so the highest port index and then the init port take priority.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < NUM_PORTS; k++)
            if (wrEnable[k]) mem[wrAddr[k]] <= wrData[k];
        if (initEnable) mem[initAddr] <= '0;
    end
endmodule

// File: rtl/lsu_dmem_np.sv
// lsu_dmem_np: N-port load/store stage with 3-cycle latency and a private, reset-zeroed data memory
module lsu_dmem_np import lsu_pkg::*; #(
    parameter int NUM_PORTS  = LSU_NUM_PORTS,
    parameter int DATA_W     = LSU_DATA_W,
    parameter int DEPTH      = LSU_DEPTH,
    parameter int ADDR_W     = LSU_ADDR_W,
    parameter int REG_ADDR_W = LSU_REG_ADDR_W,
    parameter int OPCODE_W   = LSU_OPCODE_W
) (
    input  logic                               clock_i,
    input  logic                               reset_ni,
    input  logic [NUM_PORTS-1:0]               valid_i,
    input  logic [NUM_PORTS-1:0]               isWb_i,
    input  logic [NUM_PORTS*REG_ADDR_W-1:0]    wbAddress_i,
    input  logic [NUM_PORTS*OPCODE_W-1:0]      opCode_i,
    input  logic [NUM_PORTS*DATA_W-1:0]        pOperand_i,
    input  logic [NUM_PORTS*DATA_W-1:0]        sOperand_i,
    output logic                               busy_o,
    output logic [NUM_PORTS-1:0]               wbEnable_o,
    output logic [NUM_PORTS*REG_ADDR_W-1:0]    wbAddress_o,
    output logic [NUM_PORTS*DATA_W-1:0]        wbData_o,
    output logic [NUM_PORTS-1:0]               fault_o
);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    lsuState_e                            state, stateNext;
    logic [ADDR_W-1:0]                    initCnt, initCntNext;
    logic                                 initWe;
    logic [NUM_PORTS-1:0]                 s1IsWb, s2WbEn, s2Fault;
    logic [NUM_PORTS-1:0][REG_ADDR_W-1:0] s1WbAddr, s2WbAddr;
    logic [NUM_PORTS-1:0][OPCODE_W-1:0]   s1Op;
    logic [NUM_PORTS-1:0][DATA_W-1:0]     s1POp, s1SOp, s2Data, rdData, exData;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]     memAddr;
    logic [NUM_PORTS-1:0]                 inRange, isLdi, rdOp, wrOp, memWe, exFault, exWbEn;

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state   <= INIT;
            initCnt <= '0;
        end else begin
            state   <= stateNext;
            initCnt <= initCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        initCntNext = initCnt;
        initWe      = 1'b0;
        if (state == INIT) begin
            initWe      = reset_ni;
            initCntNext = initCnt + 1'b1;
            stateNext   = (initCnt == ADDR_W'(DEPTH - 1)) ? RUN : INIT;
        end
    end

    assign busy_o = (state == INIT);

    // Decode and address check; kept apart from the result mux so the read path has no block-level loop.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            inRange[k] = 32'(s1SOp[k]) < DEPTH_U;
            isLdi[k]   = s1Op[k] == OPCODE_W'(OP_LDI);
            rdOp[k]    = s1Op[k] == OPCODE_W'(OP_LD) || s1Op[k] == OPCODE_W'(OP_SWP);
            wrOp[k]    = s1Op[k] == OPCODE_W'(OP_ST) || s1Op[k] == OPCODE_W'(OP_SWP);
            memAddr[k] = inRange[k] ? ADDR_W'(s1SOp[k]) : '0;
            memWe[k]   = reset_ni && inRange[k] && wrOp[k];
            exFault[k] = !inRange[k] && (rdOp[k] || wrOp[k]);
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            exWbEn[k] = s1IsWb[k] && (isLdi[k] || (inRange[k] && rdOp[k]));
            exData[k] = isLdi[k] ? s1SOp[k] : (inRange[k] && rdOp[k]) ? rdData[k] : '0;
        end
    end

    lsu_dmem_array #(
        .NUM_PORTS (NUM_PORTS),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) uArray (
        .clock_i    (clock_i),
        .rdAddr     (memAddr),
        .rdData     (rdData),
        .wrEnable   (memWe),
        .wrAddr     (memAddr),
        .wrData     (s1POp),
        .initEnable (initWe),
        .initAddr   (initCnt)
    );

    // Dropped or invalid lanes enter S1 as NOP, so nothing stale can reach the outputs.
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            s1Op        <= '0;
            s1IsWb      <= '0;
            s1WbAddr    <= '0;
            s1POp       <= '0;
            s1SOp       <= '0;
            s2WbEn      <= '0;
            s2Fault     <= '0;
            s2WbAddr    <= '0;
            s2Data      <= '0;
            wbEnable_o  <= '0;
            fault_o     <= '0;
            wbAddress_o <= '0;
            wbData_o    <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++)
                s1Op[k] <= (valid_i[k] && !busy_o) ? opCode_i[k*OPCODE_W +: OPCODE_W] : OPCODE_W'(OP_NOP);
            s1IsWb      <= isWb_i;
            s1WbAddr    <= wbAddress_i;
            s1POp       <= pOperand_i;
            s1SOp       <= sOperand_i;
            s2WbEn      <= exWbEn;
            s2Fault     <= exFault;
            s2WbAddr    <= s1WbAddr;
            s2Data      <= exData;
            wbEnable_o  <= s2WbEn;
            fault_o     <= s2Fault;
            wbAddress_o <= s2WbAddr;
            wbData_o    <= s2Data;
        end
    end
endmodule

// File: tb/tb_lsu_dmem_np.sv
// tb_lsu_dmem_np: directed scenarios plus randomized traffic checked against a behavioural memory model
module tb_lsu_dmem_np;
    localparam int NP = 2, DW = 16, DEPTH = 2048, AW = 11, RW = 5, OW = 7;
    localparam int LDI = 10, LD = 11, ST = 12, SWP = 13;

    logic              clock_i = 1'b0;
    logic              reset_ni = 1'b1;
    logic [NP-1:0]     valid_i = '0, isWb_i = '0;
    logic [NP*RW-1:0]  wbAddress_i = '0;
    logic [NP*OW-1:0]  opCode_i = '0;
    logic [NP*DW-1:0]  pOperand_i = '0, sOperand_i = '0;
    logic              busy_o;
    logic [NP-1:0]     wbEnable_o, fault_o;
    logic [NP*RW-1:0]  wbAddress_o;
    logic [NP*DW-1:0]  wbData_o;

    int nRun = 0, nFail = 0;
    logic [DW-1:0] mdl [DEPTH];

    typedef struct {
        logic [NP-1:0]    en, flt, vld;
        logic [NP*DW-1:0] data;
        logic [NP*RW-1:0] addr;
    } exp_t;

    always #5 clock_i = ~clock_i;

    lsu_dmem_np #(
        .NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .REG_ADDR_W(RW), .OPCODE_W(OW)
    ) dut (
        .clock_i     (clock_i),
        .reset_ni    (reset_ni),
        .valid_i     (valid_i),
        .isWb_i      (isWb_i),
        .wbAddress_i (wbAddress_i),
        .opCode_i    (opCode_i),
        .pOperand_i  (pOperand_i),
        .sOperand_i  (sOperand_i),
        .busy_o      (busy_o),
        .wbEnable_o  (wbEnable_o),
        .wbAddress_o (wbAddress_o),
        .wbData_o    (wbData_o),
        .fault_o     (fault_o)
    );

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic clearOps();
        valid_i = '0; isWb_i = '0; wbAddress_i = '0; opCode_i = '0; pOperand_i = '0; sOperand_i = '0;
    endtask

    task automatic setOp(input int p, input int op, input bit wb, input int wa, input int pv, input int sv);
        valid_i[p] = 1'b1;
        isWb_i[p] = wb;
        wbAddress_i[p*RW +: RW] = RW'(wa);
        opCode_i[p*OW +: OW] = OW'(op);
        pOperand_i[p*DW +: DW] = DW'(pv);
        sOperand_i[p*DW +: DW] = DW'(sv);
    endtask

    // Issue whatever is set up, then idle until that request reaches the outputs.
    task automatic flush3();
        step();
        clearOps();
        step();
        step();
    endtask

    task automatic waitInit(output int edges);
        edges = 0;
        while (busy_o === 1'b1 && edges < DEPTH + 16) begin
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        int edges;
        bit sawEn;
        clearOps();
        reset_ni = 1'b0;
        repeat (3) step();
        nRun++;
        if ({busy_o, wbEnable_o, fault_o, wbData_o, wbAddress_o} !== {1'b1, {(2*NP + NP*(DW+RW)){1'b0}}}) begin
            nFail++;
            $display("FAIL reset_state: busy=%b en=%b flt=%b data=%h addr=%h, want busy=1 rest 0",
                     busy_o, wbEnable_o, fault_o, wbData_o, wbAddress_o);
        end
        reset_ni = 1'b1;
        setOp(0, LDI, 1, 1, 0, 16'h1234);
        setOp(1, LDI, 1, 2, 0, 16'h5678);
        edges = 0;
        sawEn = 0;
        while (busy_o === 1'b1 && edges < DEPTH + 16) begin
            step();
            edges++;
            if (wbEnable_o !== '0) sawEn = 1;
        end
        clearOps();
        nRun++;
        if (edges != DEPTH) begin
            nFail++;
            $display("FAIL busy_length: got %0d edges, want %0d", edges, DEPTH);
        end
        repeat (2) begin
            step();
            if (wbEnable_o !== '0) sawEn = 1;
        end
        nRun++;
        if (sawEn) begin
            nFail++;
            $display("FAIL busy_ignores_valid: got a writeback from a request made while busy, want none");
        end
        setOp(0, LD, 1, 3, 0, 5);
        step();
        clearOps();
        step();
        nRun++;
        if (wbEnable_o !== 2'b00) begin
            nFail++;
            $display("FAIL ld_early: got en=%b one cycle too soon, want 00", wbEnable_o);
        end
        step();
        nRun++;
        if ({wbEnable_o, fault_o, wbData_o[15:0], wbAddress_o[4:0]} !== {2'b01, 2'b00, 16'h0000, 5'd3}) begin
            nFail++;
            $display("FAIL ld_after_init: got en=%b flt=%b data=%h addr=%0d, want en=01 flt=00 data=0000 addr=3",
                     wbEnable_o, fault_o, wbData_o[15:0], wbAddress_o[4:0]);
        end
    endtask

    task automatic test_store_load();
        setOp(0, ST, 0, 0, 16'hBEEF, 16'h0010);
        step();
        clearOps();
        setOp(1, LD, 1, 7, 0, 16'h0010);
        step();
        clearOps();
        step();
        nRun++;
        if ({wbEnable_o[0], fault_o[0], wbData_o[15:0]} !== 18'h0) begin
            nFail++;
            $display("FAIL st_output: got en=%b flt=%b data=%h, want 0 0 0000", wbEnable_o[0], fault_o[0], wbData_o[15:0]);
        end
        step();
        nRun++;
        if ({wbEnable_o[1], fault_o[1], wbData_o[31:16], wbAddress_o[9:5]} !== {1'b1, 1'b0, 16'hBEEF, 5'd7}) begin
            nFail++;
            $display("FAIL st_then_ld: got en=%b flt=%b data=%h addr=%0d, want 1 0 beef 7",
                     wbEnable_o[1], fault_o[1], wbData_o[31:16], wbAddress_o[9:5]);
        end
    endtask

    task automatic test_conflict();
        setOp(0, ST, 0, 0, 16'h1111, 16'h0020);
        setOp(1, LD, 1, 8, 0, 16'h0020);
        flush3();
        nRun++;
        if ({wbEnable_o, wbData_o[31:16], wbAddress_o[9:5]} !== {2'b10, 16'h0000, 5'd8}) begin
            nFail++;
            $display("FAIL read_before_write: got en=%b data=%h addr=%0d, want en=10 data=0000 addr=8",
                     wbEnable_o, wbData_o[31:16], wbAddress_o[9:5]);
        end
        setOp(0, ST, 0, 0, 16'h1111, 16'h0020);
        setOp(1, ST, 0, 0, 16'h2222, 16'h0020);
        step();
        clearOps();
        setOp(0, LD, 1, 4, 0, 16'h0020);
        flush3();
        nRun++;
        if ({wbEnable_o, wbData_o[15:0]} !== {2'b01, 16'h2222}) begin
            nFail++;
            $display("FAIL store_priority: got en=%b data=%h, want en=01 data=2222", wbEnable_o, wbData_o[15:0]);
        end
    endtask

    task automatic test_swap();
        setOp(0, ST, 0, 0, 16'h00AA, 16'h0030);
        step();
        clearOps();
        setOp(0, SWP, 1, 2, 16'h0055, 16'h0030);
        step();
        clearOps();
        setOp(1, LD, 1, 6, 0, 16'h0030);
        step();
        clearOps();
        step();
        nRun++;
        if ({wbEnable_o[0], fault_o[0], wbData_o[15:0], wbAddress_o[4:0]} !== {1'b1, 1'b0, 16'h00AA, 5'd2}) begin
            nFail++;
            $display("FAIL swap_old: got en=%b flt=%b data=%h addr=%0d, want 1 0 00aa 2",
                     wbEnable_o[0], fault_o[0], wbData_o[15:0], wbAddress_o[4:0]);
        end
        step();
        nRun++;
        if ({wbEnable_o[1], wbData_o[31:16]} !== {1'b1, 16'h0055}) begin
            nFail++;
            $display("FAIL swap_new: got en=%b data=%h, want 1 0055", wbEnable_o[1], wbData_o[31:16]);
        end
        setOp(0, SWP, 1, 1, 16'h0001, 16'h0031);
        setOp(1, SWP, 1, 2, 16'h0002, 16'h0031);
        step();
        clearOps();
        setOp(0, LD, 1, 3, 0, 16'h0031);
        step();
        clearOps();
        step();
        nRun++;
        if ({wbEnable_o, wbData_o} !== {2'b11, 32'h0}) begin
            nFail++;
            $display("FAIL dual_swap_old: got en=%b data=%h, want en=11 data=00000000", wbEnable_o, wbData_o);
        end
        step();
        nRun++;
        if (wbData_o[15:0] !== 16'h0002) begin
            nFail++;
            $display("FAIL dual_swap_new: got %h, want 0002", wbData_o[15:0]);
        end
    endtask

    task automatic test_fault();
        setOp(0, LD, 1, 1, 0, DEPTH);
        setOp(1, ST, 1, 2, 16'h9999, 16'hFFFF);
        flush3();
        nRun++;
        if ({wbEnable_o, fault_o, wbData_o, wbAddress_o} !== {2'b00, 2'b11, 32'h0, 5'd2, 5'd1}) begin
            nFail++;
            $display("FAIL fault_ld_st: got en=%b flt=%b data=%h addr=%h, want en=00 flt=11 data=0 addr=041",
                     wbEnable_o, fault_o, wbData_o, wbAddress_o);
        end
        setOp(0, LDI, 1, 9, 0, 16'hFFFF);
        setOp(1, LD, 1, 10, 0, 16'h07FF);
        flush3();
        nRun++;
        if ({wbEnable_o, fault_o, wbData_o, wbAddress_o} !== {2'b11, 2'b00, 16'h0000, 16'hFFFF, 5'd10, 5'd9}) begin
            nFail++;
            $display("FAIL ldi_no_fault: got en=%b flt=%b data=%h addr=%h, want en=11 flt=00 data=0000ffff",
                     wbEnable_o, fault_o, wbData_o, wbAddress_o);
        end
        setOp(0, LD, 1, 1, 0, 16'h0810);
        setOp(1, SWP, 1, 2, 16'h0005, 16'h1030);
        flush3();
        nRun++;
        if ({wbEnable_o, fault_o, wbData_o} !== {2'b00, 2'b11, 32'h0}) begin
            nFail++;
            $display("FAIL fault_high_bits: got en=%b flt=%b data=%h, want en=00 flt=11 data=0",
                     wbEnable_o, fault_o, wbData_o);
        end
        setOp(0, LD, 1, 3, 0, 16'h0010);
        setOp(1, LD, 1, 4, 0, 16'h0030);
        flush3();
        nRun++;
        if (wbData_o !== {16'h0055, 16'hBEEF}) begin
            nFail++;
            $display("FAIL fault_mem_unchanged: got %h, want 0055beef", wbData_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges;
        setOp(0, LDI, 1, 11, 0, 16'hABCD);
        step();
        clearOps();
        setOp(0, ST, 0, 0, 16'h1234, 16'h0040);
        step();
        clearOps();
        reset_ni = 1'b0;
        step();
        reset_ni = 1'b1;
        nRun++;
        if ({busy_o, wbEnable_o, fault_o, wbData_o, wbAddress_o} !== {1'b1, {(2*NP + NP*(DW+RW)){1'b0}}}) begin
            nFail++;
            $display("FAIL mid_reset_state: busy=%b en=%b flt=%b data=%h addr=%h, want busy=1 rest 0",
                     busy_o, wbEnable_o, fault_o, wbData_o, wbAddress_o);
        end
        waitInit(edges);
        nRun++;
        if (edges != DEPTH) begin
            nFail++;
            $display("FAIL mid_reset_init: got %0d edges, want %0d", edges, DEPTH);
        end
        setOp(0, LD, 1, 12, 0, 16'h0040);
        flush3();
        nRun++;
        if ({wbEnable_o[0], wbData_o[15:0], wbAddress_o[4:0]} !== {1'b1, 16'h0000, 5'd12}) begin
            nFail++;
            $display("FAIL mid_reset_store_lost: got en=%b data=%h addr=%0d, want 1 0000 12",
                     wbEnable_o[0], wbData_o[15:0], wbAddress_o[4:0]);
        end
    endtask

    task automatic test_random();
        localparam int N = 400;
        exp_t q[$];
        exp_t e, g;
        int op[NP], sv[NP], pv[NP], wa[NP];
        bit wb[NP], vld[NP];
        int ops[7] = '{0, LDI, LD, ST, SWP, ST, LD};
        logic [NP*RW-1:0] m;
        for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
        for (int i = 0; i < N + 2; i++) begin
            clearOps();
            e = '{default: '0};
            for (int p = 0; p < NP; p++) begin
                int r;
                vld[p] = (i < N) && ($urandom_range(0, 9) < 8);
                op[p] = ($urandom_range(0, 7) == 7) ? int'($urandom_range(0, 127)) : ops[$urandom_range(0, 6)];
                r = $urandom_range(0, 9);
                sv[p] = (r < 6) ? int'($urandom_range(16'h100, 16'h10F))
                      : (r < 8) ? int'($urandom_range(DEPTH - 2, DEPTH + 1)) : int'($urandom_range(0, 65535));
                pv[p] = $urandom_range(0, 65535);
                wa[p] = $urandom_range(0, 31);
                wb[p] = 1'($urandom_range(0, 1));
                if (vld[p]) setOp(p, op[p], wb[p], wa[p], pv[p], sv[p]);
            end
            for (int p = 0; p < NP; p++) begin
                logic rdOk;
                rdOk = vld[p] && sv[p] < DEPTH && (op[p] == LD || op[p] == SWP);
                e.vld[p] = vld[p];
                e.en[p] = vld[p] && wb[p] && (op[p] == LDI || rdOk);
                e.flt[p] = vld[p] && sv[p] >= DEPTH && op[p] >= LD && op[p] <= SWP;
                e.data[p*DW +: DW] = (vld[p] && op[p] == LDI) ? DW'(sv[p]) : rdOk ? mdl[sv[p]] : '0;
                e.addr[p*RW +: RW] = RW'(wa[p]);
            end
            for (int p = 0; p < NP; p++)
                if (vld[p] && sv[p] < DEPTH && (op[p] == ST || op[p] == SWP)) mdl[sv[p]] = DW'(pv[p]);
            q.push_back(e);
            step();
            if (q.size() == 3) begin
                g = q.pop_front();
                for (int p = 0; p < NP; p++) m[p*RW +: RW] = {RW{g.vld[p]}};
                nRun++;
                if ({wbEnable_o, fault_o, wbData_o} !== {g.en, g.flt, g.data} || (wbAddress_o & m) !== (g.addr & m)) begin
                    nFail++;
                    $display("FAIL random[%0d]: got en=%b flt=%b data=%h addr=%h, want en=%b flt=%b data=%h addr=%h",
                             i, wbEnable_o, fault_o, wbData_o, wbAddress_o & m, g.en, g.flt, g.data, g.addr & m);
                end
            end
        end
        clearOps();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_conflict();
        test_swap();
        test_fault();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end
endmodule
